game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter NUM_CELLS, default 10: number of 4-bit BCD cells in the status word; legal range 2..10.
REQ-002 Parameter INIT_STATUS, default 40'h0: status value loaded at reset; each nibble SHALL be 0..9.
REQ-003 vga_clk  in  1  sole clock, pixel clock domain; all logic on rising edge.
REQ-004 vga_rst  in  1  reset, synchronous, active-high.
REQ-005 btn_left  in  1  single-cycle pulse, debounced upstream.
REQ-006 btn_right  in  1  single-cycle pulse.
REQ-007 btn_ok  in  1  single-cycle pulse.
REQ-008 btn_back  in  1  single-cycle pulse.
REQ-009 frame_start  in  1  single-cycle strobe at start of vertical blank.
REQ-010 status  out  40  display copy of cells; nibble i = cell i; nibbles >= NUM_CELLS read 0.
REQ-011 predict  out  4  display copy of the pending edit value.
REQ-012 selecting  out  1  display copy: 1 while a cell is being edited.
REQ-013 cur_select  out  4  display copy of cursor index, 0..NUM_CELLS-1.
REQ-014 selected  out  4  display copy of index being edited; 4'hF when not editing.
REQ-015 commit_pulse  out  1  one-cycle pulse, immediate (not frame-aligned), when an edit is written.
REQ-016 commit_index  out  4  cell index written, valid with commit_pulse.

Function
REQ-017 Working registers: cells, cursor, edit_val, edit_idx, FSM state; they change on the edge after the qualifying button pulse.
REQ-018 FSM states: BROWSE, EDIT, COMMIT; COMMIT lasts exactly one cycle, then returns to BROWSE.
REQ-019 Same-cycle button priority: back > ok > right > left; only the highest-priority pulse acts, others are dropped.
REQ-020 BROWSE: left decrements cursor, 0 wraps to NUM_CELLS-1; right increments, NUM_CELLS-1 wraps to 0; back ignored.
REQ-021 BROWSE + ok: edit_idx <= cursor, edit_val <= cells[cursor], go to EDIT.
REQ-022 EDIT: right increments edit_val mod 10 (9 -> 0); left decrements (0 -> 9); cursor frozen.
REQ-023 EDIT + back: discard edit_val, cells unchanged, go to BROWSE, no commit_pulse.
REQ-024 EDIT + ok: go to COMMIT; in COMMIT cells[edit_idx] <= edit_val, commit_pulse = 1, commit_index = edit_idx.
REQ-025 COMMIT: all button pulses ignored.
REQ-026 commit_pulse SHALL be high only in COMMIT; commit_index holds its last value otherwise.
REQ-027 Display outputs status/predict/selecting/cur_select/selected load from working registers only in cycles with frame_start = 1; visible the following cycle; otherwise held.
REQ-028 On frame_start the pre-edge working values are captured; a button acting in the same cycle is shown at the next frame_start.
REQ-029 Displayed predict = edit_val while in EDIT or COMMIT, else cells[cursor]; selecting = 1 in EDIT or COMMIT.
REQ-030 Arithmetic is 4-bit; no nibble of cells or edit_val ever holds a value > 9.

Reset
REQ-031 On vga_clk edge with vga_rst = 1: state BROWSE, cells = INIT_STATUS, cursor = 0, edit_val = 0, edit_idx = 4'hF.
REQ-032 Reset outputs: status = INIT_STATUS, predict = INIT_STATUS[3:0], selecting = 0, cur_select = 0, selected = 4'hF, commit_pulse = 0, commit_index = 0.
REQ-033 Reset mid-EDIT or in COMMIT aborts without writing cells; reset dominates frame_start and buttons.

Structure
REQ-034 Shared package game_pkg holds the FSM state encoding, CELL_W = 4, SEL_NONE = 4'hF, and the BCD increment/decrement functions.
REQ-035 One sub-module, frame_latch: a generic frame_start-gated register bank for the display outputs.

Verification
REQ-036 Reset, then 3x btn_right and a frame_start -> cur_select = 3, selecting = 0, selected = F.
REQ-037 Cursor 0 + btn_left -> cursor 9 (NUM_CELLS = 10); cursor 9 + btn_right -> 0.
REQ-038 Cell 2 = 8: ok, right, right, ok -> commit_pulse one cycle, commit_index = 2, status[11:8] = 0 after the next frame_start.
REQ-039 EDIT with edit_val 5, then btn_back -> no commit_pulse, cell unchanged, selected = F after frame_start.
REQ-040 btn_ok and btn_back in the same cycle during EDIT -> cancel wins; btn_left and btn_right together in BROWSE -> cursor increments.
REQ-041 Button pulse in the same cycle as frame_start -> display shows the old value; the change appears after the next frame_start; vga_rst in COMMIT -> status = INIT_STATUS.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game controller: FSM encoding, cell width and
// modulo-10 step helpers used on the BCD cells.
package game_pkg;

    localparam int unsigned CELL_W = 4;
    localparam logic [CELL_W-1:0] SEL_NONE = 4'hF;

    typedef enum logic [1:0] {
        StBrowse = 2'd0,
        StEdit   = 2'd1,
        StCommit = 2'd2
    } state_t;

    function automatic logic [CELL_W-1:0] bcd_inc(input logic [CELL_W-1:0] v);
        return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [CELL_W-1:0] bcd_dec(input logic [CELL_W-1:0] v);
        return (v == 4'd0) ? 4'd9 : v - 4'd1;
    endfunction

endpackage

// File: rtl/frame_latch.sv
// Register bank that only loads on frame_start, so the display path sees
// values that stay stable for a whole frame.
module frame_latch #(
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else if (load) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/game_ctrl.sv
// Cursor/edit controller for a row of BCD cells; button pulses act
// immediately, display copies refresh only on frame_start.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned NUM_CELLS   = 10,
    parameter logic [39:0] INIT_STATUS = 40'h0
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_ok,
    input  logic        btn_back,
    input  logic        frame_start,
    output logic [39:0] status,
    output logic [3:0]  predict,
    output logic        selecting,
    output logic [3:0]  cur_select,
    output logic [3:0]  selected,
    output logic        commit_pulse,
    output logic [3:0]  commit_index
);

    localparam logic [39:0] STATUS_MASK =
        (NUM_CELLS >= 10) ? {40{1'b1}} : ((40'h1 << (4 * NUM_CELLS)) - 40'h1);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_CELLS - 1);
    localparam int unsigned DISP_W   = 40 + 4 + 1 + 4 + 4;
    localparam logic [DISP_W-1:0] DISP_RESET =
        {INIT_STATUS & STATUS_MASK, INIT_STATUS[3:0], 1'b0, 4'h0, SEL_NONE};

    state_t            state_q, state_d;
    logic [CELL_W-1:0] cells_q [NUM_CELLS];
    logic [CELL_W-1:0] cells_d [NUM_CELLS];
    logic [3:0]        cursor_q, cursor_d;
    logic [3:0]        edit_val_q, edit_val_d;
    logic [3:0]        edit_idx_q, edit_idx_d;
    logic [3:0]        commit_index_q, commit_index_d;

    logic act_back, act_ok, act_right, act_left;
    logic [3:0] cur_cell;
    logic [39:0] status_w;
    logic editing;

    // Strict priority: only the highest pending pulse is considered.
    assign act_back  = btn_back;
    assign act_ok    = btn_ok & ~btn_back;
    assign act_right = btn_right & ~btn_ok & ~btn_back;
    assign act_left  = btn_left & ~btn_right & ~btn_ok & ~btn_back;

    always_comb begin
        cur_cell = '0;
        status_w = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            if (cursor_q == 4'(i)) cur_cell = cells_q[i];
            status_w[i*4 +: 4] = cells_q[i];
        end
    end

    always_comb begin
        state_d        = state_q;
        cells_d        = cells_q;
        cursor_d       = cursor_q;
        edit_val_d     = edit_val_q;
        edit_idx_d     = edit_idx_q;
        commit_index_d = commit_index_q;
        unique case (state_q)
            StBrowse: begin
                if (act_ok) begin
                    edit_idx_d = cursor_q;
                    edit_val_d = cur_cell;
                    state_d    = StEdit;
                end else if (act_right) begin
                    cursor_d = (cursor_q == LAST_IDX) ? 4'd0 : cursor_q + 4'd1;
                end else if (act_left) begin
                    cursor_d = (cursor_q == 4'd0) ? LAST_IDX : cursor_q - 4'd1;
                end
            end
            StEdit: begin
                if (act_back) begin
                    state_d = StBrowse;
                end else if (act_ok) begin
                    // Index is published now so it is valid alongside the pulse.
                    commit_index_d = edit_idx_q;
                    state_d        = StCommit;
                end else if (act_right) begin
                    edit_val_d = bcd_inc(edit_val_q);
                end else if (act_left) begin
                    edit_val_d = bcd_dec(edit_val_q);
                end
            end
            StCommit: begin
                for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                    if (edit_idx_q == 4'(i)) cells_d[i] = edit_val_q;
                end
                state_d = StBrowse;
            end
            default: state_d = StBrowse;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            state_q        <= StBrowse;
            cursor_q       <= '0;
            edit_val_q     <= '0;
            edit_idx_q     <= SEL_NONE;
            commit_index_q <= '0;
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                cells_q[i] <= INIT_STATUS[i*4 +: 4];
            end
        end else begin
            state_q        <= state_d;
            cells_q        <= cells_d;
            cursor_q       <= cursor_d;
            edit_val_q     <= edit_val_d;
            edit_idx_q     <= edit_idx_d;
            commit_index_q <= commit_index_d;
        end
    end

    assign editing      = (state_q == StEdit) || (state_q == StCommit);
    assign commit_pulse = (state_q == StCommit);
    assign commit_index = commit_index_q;

    frame_latch #(
        .WIDTH     (DISP_W),
        .RESET_VAL (DISP_RESET)
    ) u_disp (
        .clk  (vga_clk),
        .rst  (vga_rst),
        .load (frame_start),
        .d    ({status_w, (editing ? edit_val_q : cur_cell), editing, cursor_q,
                (editing ? edit_idx_q : SEL_NONE)}),
        .q    ({status, predict, selecting, cur_select, selected})
    );

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised bench for game_ctrl against a behavioural model of the cell editor.
module tb_game_ctrl;

    localparam int unsigned N    = 10;
    localparam logic [39:0] INIT = 40'h1234567890;

    logic        vga_clk, vga_rst;
    logic        btn_left, btn_right, btn_ok, btn_back, frame_start;
    logic [39:0] status;
    logic [3:0]  predict, cur_select, selected, commit_index;
    logic        selecting, commit_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Model: editing/committing flags plus plain integer cells.
    int m_cells [N];
    int m_cur, m_val, m_idx, m_cidx;
    bit m_editing, m_committing;
    logic [39:0] d_status;
    int d_predict, d_cur, d_selected;
    bit d_sel;

    game_ctrl #(
        .NUM_CELLS   (N),
        .INIT_STATUS (INIT)
    ) dut (
        .vga_clk      (vga_clk),
        .vga_rst      (vga_rst),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_ok       (btn_ok),
        .btn_back     (btn_back),
        .frame_start  (frame_start),
        .status       (status),
        .predict      (predict),
        .selecting    (selecting),
        .cur_select   (cur_select),
        .selected     (selected),
        .commit_pulse (commit_pulse),
        .commit_index (commit_index)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] pack_cells();
        logic [39:0] r = '0;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(m_cells[i]);
        return r;
    endfunction

    task automatic model_step(input bit l, input bit r, input bit o, input bit b,
                              input bit f, input bit rst);
        if (rst) begin
            for (int i = 0; i < N; i++) m_cells[i] = int'(INIT[i*4 +: 4]);
            m_cur = 0; m_val = 0; m_idx = 15; m_cidx = 0;
            m_editing = 0; m_committing = 0;
            d_status = INIT; d_predict = int'(INIT[3:0]); d_sel = 0;
            d_cur = 0; d_selected = 15;
        end else begin
            if (f) begin
                d_status   = pack_cells();
                d_sel      = m_editing || m_committing;
                d_predict  = d_sel ? m_val : m_cells[m_cur];
                d_cur      = m_cur;
                d_selected = d_sel ? m_idx : 15;
            end
            if (m_committing) begin
                m_cells[m_idx] = m_val;
                m_committing = 0;
            end else if (b) begin
                m_editing = 0;
            end else if (o) begin
                if (m_editing) begin
                    m_editing = 0; m_committing = 1; m_cidx = m_idx;
                end else begin
                    m_editing = 1; m_idx = m_cur; m_val = m_cells[m_cur];
                end
            end else if (r) begin
                if (m_editing) m_val = (m_val + 1) % 10;
                else m_cur = (m_cur + 1) % N;
            end else if (l) begin
                if (m_editing) m_val = (m_val + 9) % 10;
                else m_cur = (m_cur + N - 1) % N;
            end
        end
    endtask

    task automatic step(input bit l, input bit r, input bit o, input bit b,
                        input bit f, input bit rst);
        btn_left = l; btn_right = r; btn_ok = o; btn_back = b;
        frame_start = f; vga_rst = rst;
        @(posedge vga_clk);
        model_step(l, r, o, b, f, rst);
        #1;
        check("status", 64'(status), 64'(d_status));
        check("predict", 64'(predict), 64'(d_predict));
        check("selecting", 64'(selecting), 64'(d_sel));
        check("cur_select", 64'(cur_select), 64'(d_cur));
        check("selected", 64'(selected), 64'(d_selected));
        check("commit_pulse", 64'(commit_pulse), 64'(m_committing));
        check("commit_index", 64'(commit_index), 64'(m_cidx));
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 1);
        check("rst_status", 64'(status), 64'(INIT));
        check("rst_selected", 64'(selected), 64'hF);
        check("rst_commit_pulse", 64'(commit_pulse), 64'h0);

        // Three rights then a frame: cursor 3 shown, not editing.
        repeat (3) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("browse_cur3", 64'(cur_select), 64'd3);
        check("browse_sel_none", 64'(selected), 64'hF);

        // Cell 2 holds 8: ok, right, right, ok writes 0.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("commit_pulse_hi", 64'(commit_pulse), 64'h1);
        check("commit_index_2", 64'(commit_index), 64'd2);
        step(0, 0, 0, 0, 0, 0);
        check("commit_pulse_lo", 64'(commit_pulse), 64'h0);
        step(0, 0, 0, 0, 1, 0);
        check("cell2_written", 64'(status[11:8]), 64'h0);

        // Cancel with back, and ok+back together, never commits.
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("cancel_sel_none", 64'(selected), 64'hF);
        check("cancel_cell5", 64'(status[23:20]), 64'h5);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        check("ok_back_no_pulse", 64'(commit_pulse), 64'h0);

        // Wrap both ways, left+right together, and same-cycle button with frame.
        repeat (5) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        check("wrap_left_old", 64'(cur_select), 64'd0);
        step(0, 0, 0, 0, 1, 0);
        check("wrap_left_9", 64'(cur_select), 64'd9);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("wrap_right_0", 64'(cur_select), 64'd0);

        // Reset while in COMMIT restores INIT.
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        check("rst_in_commit", 64'(status), 64'(INIT));

        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
